serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: CHUNK bits per clock, LSB slice first, with registered
// sum, unsigned carry-out and two's-complement overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_adder: need WIDTH >= 2, 1 <= CHUNK <= WIDTH, WIDTH divisible by CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, psum, psum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   slice;
  logic             last;
  logic             msb_cin;

  // Operands shift right so the active slice is always at bit 0; sum slices
  // enter from the top so the result lands aligned after N steps.
  assign slice    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  assign psum_nxt = WIDTH'({slice[CHUNK-1:0], psum} >> CHUNK);
  assign last     = (cnt == CW'(N - 1));
  // On the last step the top slice holds the operand MSBs.
  assign msb_cin  = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice[CHUNK-1];

  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      psum      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            carry <= in_c;
            psum  <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          carry <= slice[CHUNK];
          psum  <= psum_nxt;
          if (last) begin
            out_sum   <= psum_nxt;
            out_carry <= slice[CHUNK];
            out_ovf   <= slice[CHUNK] ^ msb_cin;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: cycle model on an 8/1 instance, directed 8/4 cases,
// exhaustive 4-bit sweep over every chunk size.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // WIDTH=8, CHUNK=1
  logic       start, c, busy, vld, co, ov;
  logic [7:0] a, b, sum;
  serial_adder #(.WIDTH(8), .CHUNK(1)) u8c1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_a(a), .in_b(b), .in_c(c),
    .busy(busy), .out_valid(vld), .out_sum(sum), .out_carry(co), .out_ovf(ov));

  // WIDTH=8, CHUNK=4
  logic       s84, c84, busy84, vld84, co84, ov84;
  logic [7:0] a84, b84, sum84;
  serial_adder #(.WIDTH(8), .CHUNK(4)) u8c4 (
    .clk(clk), .rst_n(rst_n), .start(s84), .in_a(a84), .in_b(b84), .in_c(c84),
    .busy(busy84), .out_valid(vld84), .out_sum(sum84), .out_carry(co84), .out_ovf(ov84));

  // WIDTH=4, CHUNK=1,2,4 sharing one stimulus
  logic       s4, c4;
  logic [3:0] a4, b4;
  logic       busy4 [3];
  logic       vld4  [3];
  logic [3:0] sum4  [3];
  logic       co4   [3];
  logic       ov4   [3];
  for (genvar g = 0; g < 3; g++) begin : g_w4
    serial_adder #(.WIDTH(4), .CHUNK(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(s4), .in_a(a4), .in_b(b4), .in_c(c4),
      .busy(busy4[g]), .out_valid(vld4[g]), .out_sum(sum4[g]), .out_carry(co4[g]),
      .out_ovf(ov4[g]));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {ovf, carry, sum} from plain integer arithmetic, signed range test for overflow.
  function automatic logic [9:0] ref_add(input int w, input int x, input int y, input int ci);
    int   full = x + y + ci;
    int   half = 1 << (w - 1);
    int   sx   = (x >= half) ? x - (1 << w) : x;
    int   sy   = (y >= half) ? y - (1 << w) : y;
    int   ss   = sx + sy + ci;
    logic o    = (ss >= half) || (ss < -half);
    return {o, 1'((full >> w) & 1), 8'(full & ((1 << w) - 1))};
  endfunction

  // Transaction-level model of the 8/1 instance: cycles remaining and last result.
  int         m_left;
  logic       m_vld;
  logic [9:0] m_out, m_pend;
  bit         chk_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_vld  <= 1'b0;
      m_out  <= '0;
      m_pend <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= 8;
        m_vld  <= 1'b0;
        m_pend <= ref_add(8, int'(a), int'(b), int'(c));
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_vld <= 1'b1;
        m_out <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_busy",  busy, m_left != 0);
      chk("model_valid", vld,  m_vld);
      chk("model_sum",   sum,  m_out[7:0]);
      chk("model_carry", co,   m_out[8]);
      chk("model_ovf",   ov,   m_out[9]);
    end
  end

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci, input bit noise,
                      input logic [7:0] prev, input logic [7:0] es, input logic ec, input logic eo);
    int lat = 0;
    int bc  = 0;
    @(negedge clk);
    a = x; b = y; c = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_prev_sum", sum, prev);
    chk("valid_drop", vld, 1'b0);
    while (!vld && lat < 20) begin
      if (busy) bc++;
      if (noise) begin
        a = 8'($urandom); b = 8'($urandom); c = 1'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency8", lat, 8);
    chk("busy_cycles8", bc, 8);
    chk("sum8", sum, es);
    chk("carry8", co, ec);
    chk("ovf8", ov, eo);
  endtask

  task automatic run84(input logic [7:0] x, input logic [7:0] y, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo);
    int lat = 0;
    @(negedge clk);
    a84 = x; b84 = y; c84 = ci; s84 = 1'b1;
    @(posedge clk); #1;
    s84 = 1'b0;
    while (!vld84 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency84", lat, 2);
    chk("sum84", sum84, es);
    chk("carry84", co84, ec);
    chk("ovf84", ov84, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
    s84 = 1'b0; a84 = '0; b84 = '0; c84 = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", vld, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_carry", co, 1'b0);
    chk("rst_ovf", ov, 1'b0);
    repeat (2) begin
      @(negedge clk);
      start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1; chk_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_valid", vld, 1'b0);
      chk("idle_sum", sum, 8'h00);
    end

    run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1);
    run8(8'h03, 8'h04, 1'b1, 1'b0, 8'h80, 8'h08, 1'b0, 1'b0);
    run8(8'h5C, 8'h3A, 1'b1, 1'b1, 8'h08, 8'h97, 1'b0, 1'b1);
    run8(8'h80, 8'h80, 1'b0, 1'b0, 8'h97, 8'h00, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("done_hold_valid", vld, 1'b1);
      chk("done_hold_sum", sum, 8'h00);
    end

    // Abort in the third BUSY cycle.
    @(negedge clk);
    a = 8'h01; b = 8'h02; c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", vld, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_carry", co, 1'b0);
    chk("abort_ovf", ov, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_abort_valid", vld, 1'b0);
      chk("post_abort_busy", busy, 1'b0);
    end
    run8(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 8'h46, 1'b0, 1'b0);

    run84(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run84(8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [9:0] e;
          int l4 [3];
          l4 = '{-1, -1, -1};
          @(negedge clk);
          a4 = 4'(x); b4 = 4'(y); c4 = 1'(ci); s4 = 1'b1;
          @(posedge clk); #1;
          s4 = 1'b0;
          for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++)
              if (vld4[g] && l4[g] < 0) l4[g] = t;
          end
          e = ref_add(4, x, y, ci);
          for (int g = 0; g < 3; g++) begin
            chk("w4_latency", l4[g], 4 >> g);
            chk("w4_sum", sum4[g], e[3:0]);
            chk("w4_carry", co4[g], e[8]);
            chk("w4_ovf", ov4[g], e[9]);
          end
        end
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
